// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
// operand_fetch
//   Decode/operand-fetch stage of a RISC-V style pipeline. It reads both source
//   operands from an asynchronous register file. It bypasses a same-cycle
//   writeback. It holds one instruction in a registered execute-side slot with
//   a valid/ready handshake on both sides. A load in the execute slot whose
//   destination is read by the incoming instruction stalls the fetch side for
//   one cycle. Each such stalled cycle is counted.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   if_valid/if_ready        : fetch-side handshake
//   if_inst, if_pc           : fetch-side payload
//   rf_addr_a/b, rf_data_a/b : register file asynchronous read ports
//   wb_we, wb_addr, wb_data  : writeback port (same as register file write)
//   flush                    : kill from a taken branch or jump
//   ex_ready                 : downstream accept
//   ex_valid, ex_pc, ex_inst : registered execute payload
//   ex_rs1_val, ex_rs2_val   : resolved source operand values
//   ex_rd                    : destination register of the held instruction
//   stall_cycles             : saturating load-use stall counter
module operand_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [4:0]  ex_rd,
  output logic [31:0] stall_cycles
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q,    ex_pc_d;
  logic [31:0] ex_inst_q,  ex_inst_d;
  logic [31:0] ex_rs1_q,   ex_rs1_d;
  logic [31:0] ex_rs2_q,   ex_rs2_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [31:0] stall_q,    stall_d;

  logic [6:0]  opcode;
  logic        uses_rs1, uses_rs2;
  logic        hazard, free, accept;
  logic        ready;

  // x0 always reads zero. Otherwise a writeback to the same register this
  // cycle is newer than the array contents. Because x0 is checked first, a
  // write with wb_addr 0 can never be bypassed.
  function automatic logic [31:0] resolve(input logic [4:0]  addr,
                                          input logic [31:0] rf_val,
                                          input logic        we,
                                          input logic [4:0]  waddr,
                                          input logic [31:0] wdata);
    logic [31:0] val;
    if (addr == 5'd0)
      val = 32'd0;
    else if (we && (waddr == addr))
      val = wdata;
    else
      val = rf_val;
    return val;
  endfunction

  assign rf_addr_a = if_inst[19:15];
  assign rf_addr_b = if_inst[24:20];

  assign opcode   = if_inst[6:0];
  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // A load's data arrives on the writeback port only in the cycle after it
  // leaves the execute slot. A dependent instruction must therefore wait one
  // bubble. After that wait, the writeback bypass supplies the value.
  assign hazard = ex_valid_q && (ex_inst_q[6:0] == OP_LOAD) && (ex_rd_q != 5'd0) &&
                  ((uses_rs1 && (ex_rd_q == rf_addr_a)) ||
                   (uses_rs2 && (ex_rd_q == rf_addr_b)));

  assign free     = !ex_valid_q || ex_ready;
  assign ready    = free && !hazard && !flush && !rst;
  assign if_ready = ready;
  assign accept   = if_valid && ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_inst_d  = ex_inst_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    stall_d    = stall_q;

    if (flush) begin
      // A kill always wins, even against a stalled downstream.
      ex_valid_d = 1'b0;
      ex_inst_d  = NOP_INST;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = if_pc;
      ex_inst_d  = if_inst;
      ex_rd_d    = if_inst[11:7];
      ex_rs1_d   = resolve(rf_addr_a, rf_data_a, wb_we, wb_addr, wb_data);
      ex_rs2_d   = resolve(rf_addr_b, rf_data_b, wb_we, wb_addr, wb_data);
    end else if (free) begin
      // Slot drained with nothing to take: insert a bubble. The remaining
      // payload is left as-is because it is meaningless while invalid.
      ex_valid_d = 1'b0;
      ex_inst_d  = NOP_INST;
    end

    if (if_valid && hazard && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_inst_q  <= NOP_INST;
      ex_rs1_q   <= 32'd0;
      ex_rs2_q   <= 32'd0;
      ex_rd_q    <= 5'd0;
      stall_q    <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_inst_q  <= ex_inst_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_inst      = ex_inst_q;
  assign ex_rs1_val   = ex_rs1_q;
  assign ex_rs2_val   = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign stall_cycles = stall_q;

endmodule
